// File: rtl/ram_bist.sv
// ram_bist: built-in self-test initiator for a single-port synchronous RAM.
//
// Runs a two-pass march over addresses 0..DEPTH-1:
//   WR0: write P(a)   RD0: read and compare P(a)
//   WR1: write ~P(a)  RD1: read and compare ~P(a)
// where P(a) = a[DATA_W-1:0] ^ SEED.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   start                one-cycle pulse; accepted only in IDLE
//   en/address/datain    RAM port (en=1 write, en=0 read)
//   dataout              RAM read data, valid READ_LATENCY clocks after the address
//   busy                 test in progress
//   done, pass           test finished / no mismatches (held until next start)
//   fail, fail_addr      sticky first-mismatch flag and its address
//   err_count            saturating mismatch count
module ram_bist #(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 8,
    parameter int                DEPTH        = 1024,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] SEED         = 8'hA5,
    parameter int                ERR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] datain,
    input  logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_DRN  = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_DONE
    } state_t;

    state_t                               state_q, state_d;
    logic   [ADDR_W-1:0]                  addr_q, addr_d;
    logic                                 en_q, en_d;
    logic   [DATA_W-1:0]                  datain_q, datain_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 pass_q, pass_d;
    logic                                 fail_q, fail_d;
    logic   [ADDR_W-1:0]                  fail_addr_q, fail_addr_d;
    logic   [ERR_W-1:0]                   err_q, err_d;
    // drain_q: all addresses of the read phase issued, waiting for the
    // last compare to come out of the latency pipe.
    logic                                 drain_q, drain_d;
    logic   [CNT_W-1:0]                   dcnt_q, dcnt_d;
    logic   [READ_LATENCY:1]              vld_pipe_q, vld_pipe_d;
    logic   [READ_LATENCY:1][ADDR_W-1:0]  addr_pipe_q, addr_pipe_d;

    logic              issue;
    logic              mismatch;
    logic [DATA_W-1:0] exp_data;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ SEED;
        return inv ? ~p : p;
    endfunction

    assign en        = en_q;
    assign address   = addr_q;
    assign datain    = datain_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign err_count = err_q;

    // A compare always completes inside the read state of its own phase,
    // so the current state tells which polarity to expect.
    assign issue    = ((state_q == S_RD0) || (state_q == S_RD1)) && !drain_q;
    assign exp_data = pat(addr_pipe_q[READ_LATENCY], state_q == S_RD1);
    assign mismatch = vld_pipe_q[READ_LATENCY] && (dataout != exp_data);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        en_d        = en_q;
        datain_d    = datain_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        err_d       = err_q;
        drain_d     = drain_q;
        dcnt_d      = dcnt_q;

        vld_pipe_d     = '0;
        addr_pipe_d    = '0;
        vld_pipe_d[1]  = issue;
        addr_pipe_d[1] = addr_q;
        for (int i = 2; i <= READ_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end

        if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = addr_pipe_q[READ_LATENCY];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    err_d       = '0;
                    addr_d      = '0;
                    en_d        = 1'b1;
                    datain_d    = pat('0, 1'b0);
                end
            end
            S_WR0, S_WR1: begin
                if (addr_q == LAST_ADDR) begin
                    state_d  = (state_q == S_WR0) ? S_RD0 : S_RD1;
                    addr_d   = '0;
                    en_d     = 1'b0;
                    datain_d = '0;
                    drain_d  = 1'b0;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    datain_d = pat(addr_q + 1'b1, state_q == S_WR1);
                end
            end
            S_RD0, S_RD1: begin
                if (!drain_q) begin
                    if (addr_q == LAST_ADDR) begin
                        // Hold the last address while the pipe drains.
                        drain_d = 1'b1;
                        dcnt_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (dcnt_q == LAST_DRN) begin
                    drain_d = 1'b0;
                    addr_d  = '0;
                    if (state_q == S_RD0) begin
                        state_d  = S_WR1;
                        en_d     = 1'b1;
                        datain_d = pat('0, 1'b1);
                    end else begin
                        // err_d includes the final compare of this cycle.
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            en_q        <= 1'b0;
            datain_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            err_q       <= '0;
            drain_q     <= 1'b0;
            dcnt_q      <= '0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            datain_q    <= datain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            err_q       <= err_d;
            drain_q     <= drain_d;
            dcnt_q      <= dcnt_d;
            vld_pipe_q  <= vld_pipe_d;
            addr_pipe_q <= addr_pipe_d;
        end
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the single-port synchronous RAM (en/address/datain/dataout interface).
- Drives the RAM's write/read port through a two-pass march: write a pattern, read and compare it, write the inverted pattern, read and compare that.
- Reports pass/fail, the first failing address and a saturating error count.
- Sits between the top-level test controller and the RAM instance.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 1024, number of words tested (addresses 0..DEPTH-1).
- READ_LATENCY, 1, clocks from address presented with en=0 to valid dataout.
- SEED, 8'hA5, pattern XOR seed (DATA_W bits).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a test; sampled only in IDLE.
- en  out  1  RAM write enable: 1 = write, 0 = read.
- address  out  ADDR_W  RAM address.
- datain  out  DATA_W  RAM write data.
- dataout  in  DATA_W  RAM read data.
- busy  out  1  test in progress.
- done  out  1  test finished; held until the next accepted start.
- pass  out  1  valid when done=1; 1 if err_count==0.
- fail  out  1  sticky; set on the first mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch.
- err_count  out  ERR_W  mismatch count, saturating at all-ones.

Behaviour:
- Reset (asynchronous, immediate): all outputs go to 0 (en, address, datain, busy, done, pass, fail, fail_addr, err_count); state goes to IDLE; all pipelines clear.
- Pattern: P(a) = a[DATA_W-1:0] ^ SEED. Phase 0 uses P(a); phase 1 uses ~P(a).
- States: IDLE → WR0 → RD0 → WR1 → RD1 → DONE.
- IDLE:
  - On start=1 at a clock edge: enter WR0, busy=1, clear done/pass/fail/fail_addr/err_count, address=0.
  - start in any other state is ignored.
- WR0 / WR1:
  - en=1 every cycle; address steps 0..DEPTH-1, one per clock; datain is the phase pattern for the current address.
  - After address DEPTH-1, go to RD0 / RD1 with address reset to 0 and en=0.
- RD0 / RD1:
  - en=0; address steps 0..DEPTH-1, one per clock.
  - Address and expected data are delayed READ_LATENCY stages, so dataout is compared against the pattern of the address issued READ_LATENCY clocks earlier.
  - After the last address, hold for READ_LATENCY drain cycles until the final compare completes, then go to WR1 / DONE.
  - datain is don't-care; drive 0.
- Mismatch at a compare:
  - err_count increments, holding at 2^ERR_W-1.
  - If fail=0, set fail=1 and fail_addr = the delayed address.
  - Later mismatches do not change fail_addr.
- DONE:
  - On the clock that enters DONE, busy=0, done=1 and pass=(err_count==0), including any compare in that same cycle.
  - Then return to IDLE with done/pass/fail/fail_addr/err_count held until the next start.
- Timing: busy is high for exactly 4*DEPTH + 2*READ_LATENCY cycles.
- Address wrap: address never exceeds DEPTH-1; the counter reloads to 0 at each phase change.
- Reset during any state aborts the test; no partial done is produced. A subsequent start runs the full sequence.
- start asserted in the same cycle reset deasserts is ignored until the first clean clock edge.

Test Plan:
- Fault-free RAM model, start pulse → busy rises next edge and stays high 4098 cycles; done=1, pass=1, fail=0, err_count=0.
- Observe the write phases → at address 800: WR0 drives en=1, datain=8'h85; WR1 drives en=1, datain=8'h7A. Addresses run 0..1023 with no gaps.
- RAM model with dataout bit 3 stuck at 1 for address 800 only → fail=1, fail_addr=800, err_count=1 (phase-0 mismatch only), pass=0.
- RAM model with dataout stuck at 8'h00 → 2040 mismatches; err_count saturates at 255, fail_addr=0, pass=0.
- Second start pulse during RD0 → ignored; sequence and total duration unchanged; single done.
- Assert rst mid-RD1 → all outputs 0 immediately, without waiting for a clock edge; after release, a new start completes with pass=1 on the fault-free model.
